// File: rtl/cla64_operand_loader_pkg.sv
// Shared types and elaboration helpers for the CLA64 operand loader.
// Word-count derivation and width sanity check live here so every user agrees.
package cla64_operand_loader_pkg;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    ISSUE  = 2'd2
  } ld_state_t;

  function automatic int calc_nw(input int op_w, input int word_w);
    return op_w / word_w;
  endfunction

  function automatic int calc_idx_w(input int nw);
    return (nw > 1) ? $clog2(nw) : 1;
  endfunction

  // Operands must split into whole words; a remainder would leave bits never written.
  function automatic bit cfg_ok(input int op_w, input int word_w);
    return (word_w > 0) && (op_w >= word_w) && ((op_w % word_w) == 0);
  endfunction

endpackage

// File: rtl/cla64_operand_loader_word_packer.sv
// operand_word_packer: writes one WORD_W slice of an OP_W register per enabled cycle.
// Slices not addressed keep their previous contents.
module operand_word_packer
  import cla64_operand_loader_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int OP_W   = 64,
  parameter int IDX_W  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [WORD_W-1:0] i_word,
  output logic [OP_W-1:0]   o_op
);

  logic [OP_W-1:0] r_op;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_op <= '0;
    end else if (i_wr_en) begin
      r_op[int'(i_idx)*WORD_W +: WORD_W] <= i_word;
    end
  end

  assign o_op = r_op;

endmodule

// File: rtl/cla64_operand_loader.sv
// Assembles two OP_W operands plus carry-in from a WORD_W stream and issues them
// to the CLA adder as one held transaction; counts completed issues.
module cla64_operand_loader
  import cla64_operand_loader_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int OP_W   = 64,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [WORD_W-1:0] i_in_data,
  input  logic              i_in_cin,
  output logic              o_op_valid,
  input  logic              i_op_ready,
  output logic [OP_W-1:0]   o_op_a,
  output logic [OP_W-1:0]   o_op_b,
  output logic              o_op_cin,
  output logic [CNT_W-1:0]  o_issued_cnt
);

  localparam int NW    = calc_nw(OP_W, WORD_W);
  localparam int IDX_W = calc_idx_w(NW);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

  if (!cfg_ok(OP_W, WORD_W)) begin : g_cfg_err
    $error("cla64_operand_loader: OP_W must be a whole multiple of WORD_W");
  end

  ld_state_t        r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_in_ready;
  logic             r_op_valid;
  logic             r_op_cin;
  logic [CNT_W-1:0] r_cnt;

  logic w_accept;
  logic w_wr_a;
  logic w_wr_b;

  assign w_accept = i_in_valid && r_in_ready;
  assign w_wr_a   = w_accept && (r_state == LOAD_A);
  assign w_wr_b   = w_accept && (r_state == LOAD_B);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= LOAD_A;
      r_idx      <= '0;
      r_in_ready <= 1'b0;
      r_op_valid <= 1'b0;
      r_op_cin   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        LOAD_A: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            if (r_idx == '0) r_op_cin <= i_in_cin;
            if (r_idx == LAST_IDX) begin
              r_state <= LOAD_B;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        LOAD_B: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            if (r_idx == LAST_IDX) begin
              // Drop ready in the same edge so no word of the next transaction slips in.
              r_state    <= ISSUE;
              r_idx      <= '0;
              r_in_ready <= 1'b0;
              r_op_valid <= 1'b1;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        ISSUE: begin
          if (r_op_valid && i_op_ready) begin
            r_cnt      <= r_cnt + CNT_W'(1);
            r_state    <= LOAD_A;
            r_idx      <= '0;
            r_op_valid <= 1'b0;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= LOAD_A;
          r_idx      <= '0;
          r_in_ready <= 1'b0;
          r_op_valid <= 1'b0;
        end
      endcase
    end
  end

  operand_word_packer #(
    .WORD_W (WORD_W),
    .OP_W   (OP_W),
    .IDX_W  (IDX_W)
  ) u_pack_a (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_wr_en (w_wr_a),
    .i_idx   (r_idx),
    .i_word  (i_in_data),
    .o_op    (o_op_a)
  );

  operand_word_packer #(
    .WORD_W (WORD_W),
    .OP_W   (OP_W),
    .IDX_W  (IDX_W)
  ) u_pack_b (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_wr_en (w_wr_b),
    .i_idx   (r_idx),
    .i_word  (i_in_data),
    .o_op    (o_op_b)
  );

  assign o_in_ready   = r_in_ready;
  assign o_op_valid   = r_op_valid;
  assign o_op_cin     = r_op_cin;
  assign o_issued_cnt = r_cnt;

endmodule

// File: tb/tb_cla64_operand_loader.sv
// Bench for cla64_operand_loader: randomized transactions against a word-level model.
module tb_cla64_operand_loader;

  localparam int WORD_W = 16;
  localparam int OP_W   = 64;
  localparam int CNT_W  = 4;
  localparam int NW     = OP_W / WORD_W;
  localparam int TMO    = 50;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_cin;
  logic              op_valid;
  logic              op_ready;
  logic [OP_W-1:0]   op_a;
  logic [OP_W-1:0]   op_b;
  logic              op_cin;
  logic [CNT_W-1:0]  issued_cnt;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;
  longint cyc = 0;
  longint last_hs_cyc = 0;

  cla64_operand_loader #(
    .WORD_W (WORD_W),
    .OP_W   (OP_W),
    .CNT_W  (CNT_W)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_data    (in_data),
    .i_in_cin     (in_cin),
    .o_op_valid   (op_valid),
    .i_op_ready   (op_ready),
    .o_op_a       (op_a),
    .o_op_b       (op_b),
    .o_op_cin     (op_cin),
    .o_issued_cnt (issued_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [OP_W-1:0] rand_op();
    return {$urandom(), $urandom()};
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_word(input logic [WORD_W-1:0] d, input logic c);
    int n;
    n = 0;
    total++;
    if (op_valid !== 1'b0) begin
      bad++;
      $display("FAIL load_op_valid got=%b exp=0", op_valid);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_cin   = c;
    while (in_ready !== 1'b1 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) begin
      total++;
      bad++;
      $display("FAIL send_word_timeout got=in_ready_low exp=in_ready_high");
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = WORD_W'($urandom());
    in_cin   = 1'($urandom());
  endtask

  task automatic send_txn(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                          input logic c, input bit gaps);
    for (int k = 0; k < 2 * NW; k++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      if (k < NW)
        send_word(a[k*WORD_W +: WORD_W], (k == 0) ? c : 1'($urandom()));
      else
        send_word(b[(k-NW)*WORD_W +: WORD_W], 1'($urandom()));
    end
  endtask

  // Entered at the negedge right after the last B word was accepted.
  task automatic expect_issue(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                              input logic c, input int hold);
    total++;
    if (op_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL issue_flags got=v%b r%b exp=v1 r0", op_valid, in_ready);
    end
    total++;
    if (op_a !== a || op_b !== b || op_cin !== c) begin
      bad++;
      $display("FAIL issue_data got=%h/%h/%b exp=%h/%h/%b", op_a, op_b, op_cin, a, b, c);
    end
    for (int h = 0; h < hold; h++) begin
      op_ready = 1'b0;
      in_valid = 1'b1;
      in_data  = WORD_W'($urandom());
      in_cin   = 1'($urandom());
      @(negedge clk);
      total++;
      if (op_valid !== 1'b1 || in_ready !== 1'b0 || op_a !== a || op_b !== b || op_cin !== c) begin
        bad++;
        $display("FAIL hold_stable got=v%b r%b %h/%h/%b exp=v1 r0 %h/%h/%b",
                 op_valid, in_ready, op_a, op_b, op_cin, a, b, c);
      end
      total++;
      if (issued_cnt !== CNT_W'(exp_cnt)) begin
        bad++;
        $display("FAIL hold_cnt got=%0d exp=%0d", issued_cnt, CNT_W'(exp_cnt));
      end
    end
    in_valid = 1'b0;
    op_ready = 1'b1;
    @(negedge clk);
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    last_hs_cyc = cyc;
    total++;
    if (op_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL handshake_flags got=v%b r%b exp=v0 r1", op_valid, in_ready);
    end
    total++;
    if (issued_cnt !== CNT_W'(exp_cnt)) begin
      bad++;
      $display("FAIL issued_cnt got=%0d exp=%0d", issued_cnt, CNT_W'(exp_cnt));
    end
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0 || op_valid !== 1'b0 || op_a !== '0 || op_b !== '0 ||
          op_cin !== 1'b0 || issued_cnt !== '0) begin
        bad++;
        $display("FAIL reset_values got=r%b v%b %h/%h/%b c%0d exp=all_zero",
                 in_ready, op_valid, op_a, op_b, op_cin, issued_cnt);
      end
    end
    exp_cnt = 0;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_reset();
    apply_reset(3);
  endtask

  task automatic test_basic();
    logic [OP_W-1:0] a, b;
    a = 64'd2;
    b = 64'd5;
    op_ready = 1'b1;
    send_txn(a, b, 1'b0, 1'b0);
    expect_issue(a, b, 1'b0, 0);
  endtask

  task automatic test_wide();
    logic [OP_W-1:0] a, b;
    a = 64'h0000_0000_0022_0FEC;
    b = 64'h0000_0000_0096_EBF9;
    send_txn(a, b, 1'b1, 1'b1);
    expect_issue(a, b, 1'b1, 0);
    for (int t = 0; t < 3; t++) begin
      logic c;
      a = rand_op();
      b = rand_op();
      c = 1'($urandom());
      send_txn(a, b, c, 1'b1);
      expect_issue(a, b, c, 0);
    end
  endtask

  task automatic test_backpressure();
    logic [OP_W-1:0] a, b;
    a = rand_op();
    b = rand_op();
    op_ready = 1'b0;
    send_txn(a, b, 1'b1, 1'b0);
    expect_issue(a, b, 1'b1, 5);
  endtask

  task automatic test_mid_load_reset();
    for (int k = 0; k < 3; k++) send_word(WORD_W'($urandom()), 1'b1);
    apply_reset(1);
    op_ready = 1'b1;
    send_txn(64'd1, 64'd1, 1'b0, 1'b0);
    expect_issue(64'd1, 64'd1, 1'b0, 0);
    total++;
    if (issued_cnt !== CNT_W'(1)) begin
      bad++;
      $display("FAIL mid_reset_cnt got=%0d exp=1", issued_cnt);
    end
  endtask

  task automatic test_back_to_back();
    longint prev;
    apply_reset(2);
    op_ready = 1'b1;
    prev = 0;
    for (int t = 1; t <= 17; t++) begin
      logic [OP_W-1:0] a, b;
      logic c;
      a = rand_op();
      b = rand_op();
      c = 1'($urandom());
      send_txn(a, b, c, 1'b0);
      expect_issue(a, b, c, 0);
      if (t > 1) begin
        total++;
        if (last_hs_cyc - prev != longint'(2 * NW + 1)) begin
          bad++;
          $display("FAIL throughput got=%0d exp=%0d", last_hs_cyc - prev, 2 * NW + 1);
        end
      end
      prev = last_hs_cyc;
      if (t >= 15) begin
        total++;
        if (issued_cnt !== CNT_W'(t % 16)) begin
          bad++;
          $display("FAIL wrap_cnt got=%0d exp=%0d", issued_cnt, t % 16);
        end
      end
    end
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_cin   = 1'b0;
    op_ready = 1'b0;
    test_reset();
    test_basic();
    test_wide();
    test_backpressure();
    test_mid_load_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
